// File: rtl/cmsdk_fpga_sram_bank_if.sv
// ---------------------------------------------------------------------------
// cmsdk_fpga_sram_bank_if
// Host-side access bus for one SRAM bank.
//   addr   [AW]  word address          (master -> slave)
//   wdata  [DW]  write data            (master -> slave)
//   wren   [NB]  per-byte write enable (master -> slave)
//   cs           access strobe         (master -> slave)
//   rdata  [DW]  read data, 0 when !rvalid (slave -> master)
//   rvalid       read data valid pulse (slave -> master)
//   busy         clear engine running  (slave -> master)
//   perr         parity error pulse    (slave -> master)
// ---------------------------------------------------------------------------
interface cmsdk_fpga_sram_bank_if #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 32
);
  localparam int unsigned NB = DW / 8;

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [NB-1:0] wren;
  logic          cs;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
  logic          perr;

  modport master (
    output addr, wdata, wren, cs,
    input  rdata, rvalid, busy, perr
  );

  modport slave (
    input  addr, wdata, wren, cs,
    output rdata, rvalid, busy, perr
  );
endinterface

// File: rtl/cmsdk_fpga_sram_bank.sv
// ---------------------------------------------------------------------------
// cmsdk_fpga_sram_bank
// Byte-enabled single-port SRAM bank with selectable read latency and a
// post-reset clear engine that zeroes the whole array.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   io_sram  cmsdk_fpga_sram_bank_if.slave (addr/wdata/wren/cs in,
//            rdata/rvalid/busy/perr out)
//
// Parameters: AW (depth 2**AW words), DW (multiple of 8), RD_LAT (1 or 2;
// 2 adds an output register), INIT_CLEAR (1 = zero array after reset).
//
// Optional feature: define CMSDK_SRAM_PARITY_EN to store one even-parity
// bit per byte lane and flag mismatches on perr alongside rvalid. Without
// it, perr is constant 0.
// ---------------------------------------------------------------------------
module cmsdk_fpga_sram_bank #(
  parameter int unsigned AW         = 14,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  cmsdk_fpga_sram_bank_if.slave io_sram
);
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;

  logic          w_clearing;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic [NB-1:0] w_mem_we;
  logic          w_rd_en;

  logic [DW-1:0] w_rd_data;
  logic          r_v1;
  logic          w_perr1;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave CLEAR on the cycle that writes the last address
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_CLEAR) && (r_clr_cnt == LAST_ADDR)) w_state_nxt = ST_READY;
  end

  // Output decode: array port steering and access classification
  always_comb begin
    w_clearing  = 1'b0;
    w_mem_addr  = io_sram.addr;
    w_mem_wdata = io_sram.wdata;
    w_mem_we    = '0;
    w_rd_en     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clearing  = 1'b1;
        w_mem_addr  = r_clr_cnt;
        w_mem_wdata = '0;
        w_mem_we    = '1;
      end
      default: begin
        if (io_sram.cs) begin
          if (io_sram.wren == '0) w_rd_en  = 1'b1;
          else                    w_mem_we = io_sram.wren;
        end
      end
    endcase
  end

  // Clear address counter
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_clr_cnt <= '0;
    else if (w_clearing) r_clr_cnt <= r_clr_cnt + AW'(1);
  end

  assign io_sram.busy = (r_state == ST_CLEAR);

  // Read-issue valid; also the output valid when RD_LAT=1
  always_ff @(posedge i_clk) begin
    if (i_rst) r_v1 <= 1'b0;
    else       r_v1 <= w_rd_en;
  end

`ifdef CMSDK_SRAM_PARITY_EN
  logic [NB-1:0] w_lane_err;
`endif

  // One array per byte lane; read register zeroes itself on non-read cycles
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd;

    always_ff @(posedge i_clk) begin
      if (w_mem_we[gi]) r_mem[w_mem_addr] <= w_mem_wdata[gi*8 +: 8];
    end

    always_ff @(posedge i_clk) begin
      if (i_rst)        r_rd <= '0;
      else if (w_rd_en) r_rd <= r_mem[w_mem_addr];
      else              r_rd <= '0;
    end

    assign w_rd_data[gi*8 +: 8] = r_rd;

`ifdef CMSDK_SRAM_PARITY_EN
    logic r_par [DEPTH];
    logic r_rd_par;

    // Even parity of the written byte; clear writes 0 which matches a zero byte
    always_ff @(posedge i_clk) begin
      if (w_mem_we[gi]) r_par[w_mem_addr] <= ^w_mem_wdata[gi*8 +: 8];
    end

    always_ff @(posedge i_clk) begin
      if (i_rst)        r_rd_par <= 1'b0;
      else if (w_rd_en) r_rd_par <= r_par[w_mem_addr];
      else              r_rd_par <= 1'b0;
    end

    assign w_lane_err[gi] = (^r_rd) ^ r_rd_par;
`endif
  end

`ifdef CMSDK_SRAM_PARITY_EN
  assign w_perr1 = r_v1 & (|w_lane_err);
`else
  assign w_perr1 = 1'b0;
`endif

  // Output stage: extra register for RD_LAT=2, otherwise straight from the read register
  if (RD_LAT >= 2) begin : g_lat2
    logic [DW-1:0] r_d2;
    logic          r_v2;
    logic          r_perr2;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_d2    <= '0;
        r_v2    <= 1'b0;
        r_perr2 <= 1'b0;
      end else begin
        r_d2    <= r_v1 ? w_rd_data : '0;
        r_v2    <= r_v1;
        r_perr2 <= w_perr1;
      end
    end

    assign io_sram.rdata  = r_d2;
    assign io_sram.rvalid = r_v2;
    assign io_sram.perr   = r_perr2;
  end else begin : g_lat1
    assign io_sram.rdata  = w_rd_data;
    assign io_sram.rvalid = r_v1;
    assign io_sram.perr   = w_perr1;
  end

endmodule

// File: tb/tb_cmsdk_fpga_sram_bank.sv
// ---------------------------------------------------------------------------
// tb_cmsdk_fpga_sram_bank
// Two banks (RD_LAT=1 and RD_LAT=2, AW=4, DW=32, INIT_CLEAR=1) receive the
// same stimulus. A word-level memory model predicts busy, rvalid and rdata
// for every edge; a negedge process compares both banks against it.
// ---------------------------------------------------------------------------
module tb_cmsdk_fpga_sram_bank;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int          NCYC  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cmsdk_fpga_sram_bank_if #(.AW(AW), .DW(DW)) if1 ();
  cmsdk_fpga_sram_bank_if #(.AW(AW), .DW(DW)) if2 ();

  cmsdk_fpga_sram_bank #(.AW(AW), .DW(DW), .RD_LAT(1), .INIT_CLEAR(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst), .io_sram(if1)
  );
  cmsdk_fpga_sram_bank #(.AW(AW), .DW(DW), .RD_LAT(2), .INIT_CLEAR(1)) u_lat2 (
    .i_clk(clk), .i_rst(rst), .io_sram(if2)
  );

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Model: memory contents plus per-edge expected outputs
  logic [31:0] m_mem [DEPTH];
  bit          exp_busy [NCYC];
  bit          ev1 [NCYC];
  bit          ev2 [NCYC];
  logic [31:0] ed1 [NCYC];
  logic [31:0] ed2 [NCYC];

  always @(posedge clk) edge_no = edge_no + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      if (failures <= 40)
        $display("FAIL %s edge=%0d actual=%h required=%h", name, edge_no, act, exp);
    end
  endtask

  // Compare process: every cycle after the first reset edge
  always @(negedge clk) begin
    if (edge_no >= 1 && edge_no < NCYC) begin
      check("busy_l1",   32'(if1.busy),   32'(exp_busy[edge_no]));
      check("busy_l2",   32'(if2.busy),   32'(exp_busy[edge_no]));
      check("rvalid_l1", 32'(if1.rvalid), 32'(ev1[edge_no]));
      check("rvalid_l2", 32'(if2.rvalid), 32'(ev2[edge_no]));
      check("rdata_l1",  if1.rdata, ev1[edge_no] ? ed1[edge_no] : 32'h0);
      check("rdata_l2",  if2.rdata, ev2[edge_no] ? ed2[edge_no] : 32'h0);
      check("perr_l1",   32'(if1.perr), 32'h0);
      check("perr_l2",   32'(if2.perr), 32'h0);
    end
  end

  // Drive one cycle of inputs (sampled at the next edge), update the model,
  // then return #1 after that edge.
  task automatic step(input bit r, input bit c, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] we);
    int s;
    s = edge_no + 1;
    rst = r;
    if1.cs = c; if1.addr = a; if1.wdata = d; if1.wren = we;
    if2.cs = c; if2.addr = a; if2.wdata = d; if2.wren = we;
    if (s + 20 < NCYC) begin
      if (r) begin
        for (int j = 0; j < DEPTH; j++) m_mem[j] = 32'h0;
        for (int j = s; j < s + DEPTH; j++) exp_busy[j] = 1'b1;
        // Reset drops anything still in flight
        for (int j = s; j < s + 3; j++) begin
          ev1[j] = 1'b0; ed1[j] = 32'h0;
          ev2[j] = 1'b0; ed2[j] = 32'h0;
        end
      end else if (!exp_busy[s-1] && c) begin
        if (we != 4'h0) begin
          for (int i = 0; i < 4; i++)
            if (we[i]) m_mem[a][i*8 +: 8] = d[i*8 +: 8];
        end else begin
          ev1[s]   = 1'b1; ed1[s]   = m_mem[a];
          ev2[s+1] = 1'b1; ed2[s+1] = m_mem[a];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  // Count busy cycles starting from the cycle after a reset edge; the first
  // idle cycle optionally carries a write that must be ignored.
  task automatic count_busy(input string name, input bit try_write);
    int n;
    n = 0;
    if (if1.busy) n = 1;
    for (int k = 0; k < 40 && if1.busy; k++) begin
      if (try_write && k == 0) step(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF);
      else if (try_write && k == 1) step(1'b0, 1'b1, 4'd5, 32'h0, 4'h0);
      else idle();
      if (if1.busy) n++;
    end
    check(name, 32'(n), 32'd16);
  endtask

  initial begin
    if1.cs = 1'b0; if1.addr = '0; if1.wdata = '0; if1.wren = '0;
    if2.cs = 1'b0; if2.addr = '0; if2.wdata = '0; if2.wren = '0;
    for (int j = 0; j < DEPTH; j++) m_mem[j] = 32'h0;
    for (int j = 0; j < NCYC; j++) begin
      exp_busy[j] = 1'b0; ev1[j] = 1'b0; ev2[j] = 1'b0; ed1[j] = 32'h0; ed2[j] = 32'h0;
    end

    // Reset and clear; a write and a read during busy are ignored
    step(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
    check("reset_busy", 32'(if1.busy), 32'h1);
    check("reset_rvalid", 32'(if2.rvalid), 32'h0);
    count_busy("clear_len", 1'b1);

    // Every address reads zero after the clear, including address 5
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 1'b1, 4'(a), 32'h0, 4'h0);
      check("clear_rdata", if1.rdata, 32'h0);
      check("clear_rvalid", 32'(if1.rvalid), 32'h1);
    end
    idle();

    // Byte-lane write merge
    step(1'b0, 1'b1, 4'd3, 32'hAABBCCDD, 4'b1111);
    check("write_no_rvalid", 32'(if1.rvalid), 32'h0);
    step(1'b0, 1'b1, 4'd3, 32'h11223344, 4'b0101);
    step(1'b0, 1'b1, 4'd3, 32'h0, 4'b0000);
    check("bytelane_l1", if1.rdata, 32'hAA22CC44);
    idle();
    check("bytelane_l2", if2.rdata, 32'hAA22CC44);

    // Back-to-back reads on the two-cycle bank
    step(1'b0, 1'b1, 4'd1, 32'h1111_0001, 4'hF);
    step(1'b0, 1'b1, 4'd2, 32'h2222_0002, 4'hF);
    step(1'b0, 1'b1, 4'd3, 32'h3333_0003, 4'hF);
    step(1'b0, 1'b1, 4'd1, 32'h0, 4'h0);
    check("lat2_first_v", 32'(if2.rvalid), 32'h0);
    check("lat2_first_d", if2.rdata, 32'h0);
    step(1'b0, 1'b1, 4'd2, 32'h0, 4'h0);
    check("lat2_r1", if2.rdata, 32'h1111_0001);
    step(1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
    check("lat2_r2", if2.rdata, 32'h2222_0002);
    idle();
    check("lat2_r3", if2.rdata, 32'h3333_0003);
    check("lat2_r3_v", 32'(if2.rvalid), 32'h1);
    idle();
    check("lat2_drain_v", 32'(if2.rvalid), 32'h0);

    // Reset between issue and return of a two-cycle read
    step(1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
    check("inflight_v", 32'(if2.rvalid), 32'h0);
    check("inflight_d", if2.rdata, 32'h0);

    // Reset again with the clear counter at 7
    for (int k = 0; k < 7; k++) idle();
    step(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
    count_busy("midclear_len", 1'b0);

    // Randomised traffic with occasional resets
    for (int it = 0; it < 2000; it++) begin
      bit          r;
      bit          c;
      logic [3:0]  we;
      r  = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(r, c, 4'($urandom_range(0, 15)), 32'($urandom), we);
    end
    idle();
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmsdk_fpga_sram_bank.md
Name: cmsdk_fpga_sram_bank

Overview:
- Parametrised, byte-enabled, single-port on-chip SRAM bank for the CMSDK-style AHB SRAM path.
- Generalises the fixed 32-bit instance in four ways: configurable data width, configurable depth, selectable read latency of 1 or 2 cycles, and a post-reset hardware clear engine.
- Sits behind the AHB-to-SRAM bridge. Code and data memories instantiate one bank each.

Parameters:
- AW, 14, address width; depth DEPTH = 2**AW words.
- DW, 32, data width; must be a multiple of 8. NB = DW/8 byte lanes.
- RD_LAT, 1, read latency in cycles. Legal values are 1 and 2; 2 adds an output register.
- INIT_CLEAR, 1, 1 = zero the whole array after every reset; 0 = skip the clear.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ADDR  in  AW  word address.
- WDATA  in  DW  write data.
- WREN  in  NB  per-byte write enables.
- CS  in  1  chip select; marks an access cycle.
- RDATA  out  DW  read data; zero when not valid.
- RVALID  out  1  one-cycle pulse with each read's data.
- BUSY  out  1  clear engine running; host accesses are ignored.
- PERR  out  1  parity error flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (RST high at a CLK edge):
  - State goes to CLEAR if INIT_CLEAR=1, otherwise to READY.
  - Clear counter = 0; read pipeline valid bits = 0.
  - RDATA = 0, RVALID = 0, PERR = 0.
  - BUSY = 1 if INIT_CLEAR=1, else 0, from the first cycle after the reset edge.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes all-zero (all byte lanes) to the address held in the counter, then increments the counter.
  - The cycle that writes DEPTH-1 transitions to READY. The clear takes exactly DEPTH cycles; BUSY deasserts on the first READY cycle.
  - CS, WREN, ADDR and WDATA are ignored; no RVALID is generated.
  - Reset asserted mid-clear restarts the clear from address 0.
- READY, access types:
  - CS=1, WREN=0: read.
  - CS=1, WREN!=0: write. Only lanes with WREN[i]=1 are updated; other lanes keep their contents.
  - CS=0: idle. WREN is ignored and nothing is written.
- Read latency:
  - A read issued at edge N presents RDATA and RVALID=1 after edge N+RD_LAT, for one cycle.
  - Back-to-back reads give one result per cycle, fully pipelined.
- Writes never produce RVALID.
- RDATA is forced to 0 in any cycle with RVALID=0.
- Read after write: a read of the same address in the cycle after a write returns the new data. The array is read-first within a cycle, and only one access can occur per cycle.
- Reset during an in-flight read (RD_LAT=2): the pending RVALID is dropped; RDATA and RVALID stay 0.
- All addresses are legal because DEPTH = 2**AW, so there is no wrap or out-of-range case.
- Inference: one byte-lane write process per lane plus a registered address/read, so synthesis maps the array to block RAM.

Optional Feature:
- Macro: CMSDK_SRAM_PARITY_EN.
- With the macro defined:
  - Each byte lane stores an extra even-parity bit, computed from WDATA on every write. CLEAR writes parity 0, which is correct for a zero byte.
  - On each read the parity is rechecked alongside RDATA. PERR pulses with RVALID if any lane mismatches. Data is still returned uncorrected.
- Without the macro: no parity storage, and PERR is constant 0.

Test Plan:
- Reset clear, INIT_CLEAR=1, AW=4: assert RST for 1 cycle → BUSY=1 for exactly 16 cycles. Then reads of address 0..15 all return 0x00000000 with RVALID.
- Byte-lane write, DW=32: write 0xAABBCCDD with WREN=4'b1111 to address 3, then 0x11223344 with WREN=4'b0101 → read of address 3 returns 0xAA22CC44.
- Latency, RD_LAT=2: reads of addresses 1, 2, 3 on consecutive edges → RVALID is high on 3 consecutive cycles starting 2 edges after the first read, with data in issue order. RDATA=0 in every cycle where RVALID=0.
- Access during clear: CS=1, WREN=4'hF, WDATA=0xDEADBEEF to address 5 while BUSY=1 → after the clear, address 5 reads 0; no RVALID during BUSY.
- Reset mid-operation: assert RST when the clear counter = 7 → BUSY stays high a full DEPTH cycles from the new reset. Separately, with RD_LAT=2, RST between issue and return of a read → no RVALID.
- Parity (CMSDK_SRAM_PARITY_EN): write 0x01020304, then force-flip bit 0 of the stored lane-0 byte → read returns 0x01020305 with PERR=1. An unmodified word reads back with PERR=0.
